ball_direction_ctrl: RTL and testbench

- Upstream of the ball horizontal position counter: produces its horizontal direction input.
- Per frame, latches ball/paddle coincidences and ball/screen-edge contacts during the visible area.
- At the start of vertical blank it decides a bounce, a miss or no change, so the direction is stable for the whole blanking interval in which the ball moves.
- Runs the serve delay after a miss and reports hits and misses to score and speed logic.

---
 rtl/ball_direction_ctrl_pkg.sv | 10 +
 rtl/ball_direction_ctrl_if.sv | 22 ++
 rtl/ball_direction_ctrl_frame_contact_latch.sv | 34 +++
 rtl/ball_direction_ctrl.sv | 72 +++++++
 tb/tb_ball_direction_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/ball_direction_ctrl_pkg.sv
// ball_direction_ctrl_pkg: direction codes, serve default and FSM state encoding for the ball direction controller.
package ball_direction_ctrl_pkg;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  localparam int SERVE_FRAMES = 60;
  typedef enum logic {ST_SERVE, ST_PLAY} state_t;
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/ball_direction_ctrl_if.sv
// ball_direction_ctrl_if: video timing/contact inputs and direction/score outputs of the ball direction controller.
interface ball_direction_ctrl_if;
  logic hblank;
  logic vblank;
  logic ball_video;
  logic paddle_l_video;
  logic paddle_r_video;
  logic hdir;
  logic active;
  logic hit;
  logic miss_l;
  logic miss_r;
  logic [7:0] rally;
  modport master (
    output hblank, vblank, ball_video, paddle_l_video, paddle_r_video,
    input hdir, active, hit, miss_l, miss_r, rally
  );
  modport slave (
    input hblank, vblank, ball_video, paddle_l_video, paddle_r_video,
    output hdir, active, hit, miss_l, miss_r, rally
  );
endinterface

// File: rtl/ball_direction_ctrl_frame_contact_latch.sv
// frame_contact_latch: per-frame sticky paddle/edge contact flags and the registered vblank-rise frame event.
module frame_contact_latch (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic hblank,
  input  logic vblank,
  input  logic ball_video,
  input  logic paddle_l_video,
  input  logic paddle_r_video,
  output logic fe,
  output logic hit_l,
  output logic hit_r,
  output logic edge_l,
  output logic edge_r
);
  logic hblank_q, vblank_q, ball_q, vis;
  assign vis = ~hblank & ~vblank;
  // edge_r fires on hblank rise, so it looks at the ball from the last visible pixel
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      {hblank_q, vblank_q, ball_q, fe} <= '0;
      {hit_l, hit_r, edge_l, edge_r} <= '0;
    end else begin
      hblank_q <= hblank;
      vblank_q <= vblank;
      ball_q <= ball_video;
      fe <= vblank & ~vblank_q;
      hit_l <= ~fe & (hit_l | (vis & ball_video & paddle_l_video));
      hit_r <= ~fe & (hit_r | (vis & ball_video & paddle_r_video));
      edge_l <= ~fe & (edge_l | (vis & hblank_q & ball_video));
      edge_r <= ~fe & (edge_r | (hblank & ~hblank_q & ~vblank & ball_q));
    end
  end
endmodule

// File: rtl/ball_direction_ctrl.sv
// ball_direction_ctrl: decides bounce/miss once per frame at vblank start and runs the serve delay.
module ball_direction_ctrl
  import ball_direction_ctrl_pkg::*;
#(
  parameter int p_SERVE_FRAMES = SERVE_FRAMES,
  parameter logic p_INIT_DIR = DIR_RIGHT
) (
  input logic i_Clk,
  input logic i_Rst_n,
  ball_direction_ctrl_if.slave bus
);
  localparam int CW = cnt_width(p_SERVE_FRAMES);
  localparam logic [CW-1:0] LOAD = CW'(p_SERVE_FRAMES);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] rally_nxt;
  logic fe, hit_l, hit_r, edge_l, edge_r;
  frame_contact_latch u_latch (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .hblank         (bus.hblank),
    .vblank         (bus.vblank),
    .ball_video     (bus.ball_video),
    .paddle_l_video (bus.paddle_l_video),
    .paddle_r_video (bus.paddle_r_video),
    .fe             (fe),
    .hit_l          (hit_l),
    .hit_r          (hit_r),
    .edge_l         (edge_l),
    .edge_r         (edge_r)
  );
  assign rally_nxt = (&bus.rally) ? bus.rally : bus.rally + 8'd1;
  // misses are tested first so an edge contact beats a paddle hit in the same frame
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_SERVE;
      cnt <= LOAD;
      bus.hdir <= p_INIT_DIR;
      bus.active <= 1'b0;
      {bus.hit, bus.miss_l, bus.miss_r} <= '0;
      bus.rally <= '0;
    end else begin
      {bus.hit, bus.miss_l, bus.miss_r} <= '0;
      if (fe && state == ST_PLAY) begin
        if (bus.hdir == DIR_LEFT && edge_l) begin
          bus.miss_l <= 1'b1;
          bus.active <= 1'b0;
          bus.rally <= '0;
          state <= ST_SERVE;
          cnt <= LOAD;
        end else if (bus.hdir == DIR_RIGHT && edge_r) begin
          bus.miss_r <= 1'b1;
          bus.active <= 1'b0;
          bus.rally <= '0;
          state <= ST_SERVE;
          cnt <= LOAD;
        end else if ((bus.hdir == DIR_LEFT && hit_l) || (bus.hdir == DIR_RIGHT && hit_r)) begin
          bus.hdir <= ~bus.hdir;
          bus.hit <= 1'b1;
          bus.rally <= rally_nxt;
        end
      end else if (fe) begin
        if (cnt <= CW'(1)) begin
          state <= ST_PLAY;
          bus.active <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ball_direction_ctrl.sv
// tb_ball_direction_ctrl: frame-driven scoreboard bench for ball_direction_ctrl on a small raster.
module tb_ball_direction_ctrl;
  localparam int SF = 3;
  localparam int W = 12, HB = 4, V = 6, VB = 2;
  localparam int LINE = W + HB;
  localparam int G0 = V * LINE;
  typedef struct packed {
    logic [2:0] pulse;
    logic hdir;
    logic active;
    logic [7:0] rally;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_err = 0;
  exp_t sb[$];
  bit m_play, m_hdir, m_active, m_hl, m_hr, m_el, m_er;
  int m_cnt, m_rally;
  ball_direction_ctrl_if bus ();
  ball_direction_ctrl #(.p_SERVE_FRAMES(SF), .p_INIT_DIR(1'b0)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] pulses();
    return {bus.hit, bus.miss_l, bus.miss_r};
  endfunction
  task automatic model_reset();
    m_play = 0; m_hdir = 0; m_active = 0; m_cnt = SF; m_rally = 0;
    {m_hl, m_hr, m_el, m_er} = '0;
  endtask
  task automatic check_reset_vals();
    chk("rst_pulse", 32'(pulses()), 0);
    chk("rst_hdir", 32'(bus.hdir), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_rally", 32'(bus.rally), 0);
  endtask
  task automatic decide();
    exp_t e;
    e.pulse = 3'b000;
    if (m_play) begin
      if (m_hdir && m_el) begin
        e.pulse = 3'b010; m_active = 0; m_rally = 0; m_play = 0; m_cnt = SF;
      end else if (!m_hdir && m_er) begin
        e.pulse = 3'b001; m_active = 0; m_rally = 0; m_play = 0; m_cnt = SF;
      end else if ((m_hdir && m_hl) || (!m_hdir && m_hr)) begin
        e.pulse = 3'b100; m_hdir = !m_hdir; m_rally = (m_rally < 255) ? m_rally + 1 : 255;
      end
    end else if (m_cnt <= 1) begin
      m_play = 1; m_active = 1;
    end else begin
      m_cnt--;
    end
    {m_hl, m_hr, m_el, m_er} = '0;
    e.hdir = m_hdir; e.active = m_active; e.rally = 8'(m_rally);
    sb.push_back(e);
  endtask
  task automatic frame(input int by, input int bx, input int blen, input int plx, input int prx, input bit do_rst);
    exp_t e;
    bit vis, b, pl, pr;
    for (int l = 0; l < V + VB; l++) begin
      for (int x = 0; x < LINE; x++) begin
        int c;
        c = l * LINE + x;
        @(negedge clk);
        if (c == G0 + 1) chk("pre_pulse", 32'(pulses()), 0);
        if (c == G0 + 2) begin
          if (sb.size() == 0) chk("sb_empty", 0, 1);
          else begin
            e = sb.pop_front();
            chk("pulse", 32'(pulses()), 32'(e.pulse));
            chk("hdir", 32'(bus.hdir), 32'(e.hdir));
            chk("active", 32'(bus.active), 32'(e.active));
            chk("rally", 32'(bus.rally), 32'(e.rally));
          end
        end
        if (c == G0 + 3) begin
          chk("post_pulse", 32'(pulses()), 0);
          chk("hdir_hold", 32'(bus.hdir), 32'(m_hdir));
        end
        if (do_rst && l == by + 1 && x == W / 2) begin
          rst_n = 1'b0;
          #1 check_reset_vals();
          model_reset();
        end else if (do_rst && l == by + 1 && x == W / 2 + 1) rst_n = 1'b1;
        vis = (x < W) && (l < V);
        b = vis && l == by && x >= bx && x < bx + blen;
        pl = vis && plx >= 0 && x >= plx && x < plx + 4;
        pr = vis && prx >= 0 && x >= prx && x < prx + 4;
        bus.hblank = (x >= W);
        bus.vblank = (l >= V);
        bus.ball_video = b;
        bus.paddle_l_video = pl;
        bus.paddle_r_video = pr;
        if (rst_n && vis) begin
          m_hl |= b & pl;
          m_hr |= b & pr;
          m_el |= b && x == 0;
          m_er |= b && x == W - 1;
        end
        if (c == G0) decide();
      end
    end
  endtask
  initial begin
    bus.hblank = 1'b1; bus.vblank = 1'b0; bus.ball_video = 1'b0;
    bus.paddle_l_video = 1'b0; bus.paddle_r_video = 1'b0;
    model_reset();
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame(0, 0, 0, -1, -1, 0);
    frame(2, 6, 4, 6, 6, 0);
    frame(3, 0, 2, -1, -1, 0);
    repeat (3) frame(0, 0, 0, -1, -1, 0);
    frame(2, 4, 2, 4, -1, 0);
    frame(2, 10, 2, -1, 10, 0);
    repeat (3) frame(0, 0, 0, -1, -1, 0);
    frame(1, 0, 2, -1, -1, 0);
    frame(1, 2, 2, 2, -1, 0);
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) frame(2, 6, 2, -1, 6, 0);
      else frame(2, 6, 2, 6, -1, 0);
    end
    chk("rally_sat", 32'(bus.rally), 255);
    frame(1, 6, 2, -1, 6, 1);
    frame(0, 0, 0, -1, -1, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
